// File: rtl/packet_injector_if.sv
// Avalon-MM slave bus plus the three switch ingress ports of packet_injector.
interface packet_injector_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [3:0]  address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] data1, data2, data3;
    logic        valid1, valid2, valid3;
    logic        ready1, ready2, ready3;

    modport slave (
        input  chipselect, write, read, address, byteenable, writedata,
        input  ready1, ready2, ready3,
        output readdata, data1, data2, data3, valid1, valid2, valid3
    );

    modport master (
        output chipselect, write, read, address, byteenable, writedata,
        output ready1, ready2, ready3,
        input  readdata, data1, data2, data3, valid1, valid2, valid3
    );
endinterface

// File: rtl/packet_injector.sv
// Host-to-switch injector: Avalon-MM pushes into three FWFT FIFOs drained by valid/ready ports.
// Optional per-port SENT counters at addresses 13-15 under INJECT_SENT_COUNTERS_EN.
module packet_injector #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input logic              clk,
    input logic              reset_n,
    packet_injector_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem    [3][DEPTH];
    logic [PW-1:0] wr_ptr [3];
    logic [PW-1:0] rd_ptr [3];
    logic [LW-1:0] level  [3];
    logic [31:0]   head   [3];
    logic          egress_en;
    logic [2:0]    overflow;
    logic [2:0]    empty, full, push_req, push, pop, ready;
    logic          wr_acc, rd_acc, flush;
    logic [31:0]   rd_mux, readdata_q;

`ifdef INJECT_SENT_COUNTERS_EN
    logic [31:0]   sent [3];
`endif

    assign ready  = {bus.ready3, bus.ready2, bus.ready1};
    assign wr_acc = bus.chipselect && bus.write && (bus.byteenable == 4'hF);
    assign rd_acc = bus.chipselect && bus.read;
    assign flush  = wr_acc && (bus.address == 4'd0) && bus.writedata[1];

    // Fullness is taken from the registered level, so a pop in the same cycle never frees a slot.
    always_comb begin
        for (int unsigned n = 0; n < 3; n++) begin
            empty[n]    = (level[n] == '0);
            full[n]     = (level[n] == LW'(DEPTH));
            push_req[n] = wr_acc && (bus.address == 4'(n + 1)) && (bus.writedata != '0);
            push[n]     = push_req[n] && !full[n] && !flush;
            pop[n]      = egress_en && !empty[n] && ready[n] && !flush;
            head[n]     = empty[n] ? '0 : mem[n][rd_ptr[n]];
        end
    end

    assign bus.data1    = head[0];
    assign bus.data2    = head[1];
    assign bus.data3    = head[2];
    assign bus.valid1   = egress_en && !empty[0];
    assign bus.valid2   = egress_en && !empty[1];
    assign bus.valid3   = egress_en && !empty[2];
    assign bus.readdata = readdata_q;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            4'd0:  rd_mux = 32'(egress_en);
            4'd8:  rd_mux = 32'(level[0]);
            4'd9:  rd_mux = 32'(level[1]);
            4'd10: rd_mux = 32'(level[2]);
            4'd11: rd_mux = {21'd0, overflow, 1'b0, full, 1'b0, empty};
`ifdef INJECT_SENT_COUNTERS_EN
            4'd13: rd_mux = sent[0];
            4'd14: rd_mux = sent[1];
            4'd15: rd_mux = sent[2];
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < 3; n++) begin
            if (push[n]) mem[n][wr_ptr[n]] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned n = 0; n < 3; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                level[n]  <= '0;
            end
            egress_en  <= 1'b0;
            overflow   <= '0;
            readdata_q <= '0;
        end else begin
            if (wr_acc && bus.address == 4'd0) egress_en <= bus.writedata[0];
            if (wr_acc && bus.address == 4'd12) overflow <= '0;
            else overflow <= overflow | (push_req & full & {3{!flush}});
            for (int unsigned n = 0; n < 3; n++) begin
                if (flush) begin
                    wr_ptr[n] <= '0;
                    rd_ptr[n] <= '0;
                    level[n]  <= '0;
                end else begin
                    if (push[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
                    if (pop[n])  rd_ptr[n] <= rd_ptr[n] + 1'b1;
                    level[n] <= level[n] + LW'(push[n]) - LW'(pop[n]);
                end
            end
            if (rd_acc) readdata_q <= rd_mux;
        end
    end

`ifdef INJECT_SENT_COUNTERS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned n = 0; n < 3; n++) sent[n] <= '0;
        end else begin
            for (int unsigned n = 0; n < 3; n++) begin
                if (pop[n]) sent[n] <= sent[n] + 32'd1;
            end
        end
    end
`endif
endmodule
